// File: rtl/rr_grant_responder.sv
// Resource side of the round-robin req/grant/ack handshake: latches the granted
// channel, drains one burst of beats onto a registered stream, then pulses ack.
module rr_grant_responder #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         grant,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         ch_valid,
  input  logic [N-1:0]         ch_last,
  input  logic [N*DW-1:0]      ch_data,
  output logic [N-1:0]         ch_ready,
  output logic                 ack,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_chan,
  output logic                 out_last,
  output logic                 err_grant,
  output logic                 err_abort
);
  localparam int SW = $clog2(N);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0] G_ONE = N'(1);

  // state | meaning
  // IDLE  | waiting for a one-hot grant
  // BURST | draining beats from channel sel
  // ACK   | one-cycle ack pulse to the arbiter
  // WAIT  | hold until the arbiter moves grant off sel
  typedef enum logic [1:0] {IDLE, BURST, ACK, WAIT} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] sel, sel_nx, gidx;
  logic [BW-1:0] beat_cnt, beat_nx, beat_inc;
  logic [IW-1:0] idle_cnt, idle_nx, idle_inc;
  logic          grant_hot, grant_bad, accept, end_last, end_abort;
  logic          unused_req;

  // req is observed by the arbiter only; a dropped req never ends a burst here.
  assign unused_req = ^req;
  assign beat_inc   = beat_cnt + BW'(1);
  assign idle_inc   = idle_cnt + IW'(1);
  assign grant_hot  = (grant != '0) && ((grant & (grant - G_ONE)) == '0);

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) gidx = SW'(i);
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    beat_nx   = beat_cnt;
    idle_nx   = idle_cnt;
    ch_ready  = '0;
    ack       = 1'b0;
    accept    = 1'b0;
    end_last  = 1'b0;
    end_abort = 1'b0;
    grant_bad = 1'b0;
    case (state)
      IDLE: begin
        if (grant_hot) begin
          sel_nx   = gidx;
          beat_nx  = '0;
          idle_nx  = '0;
          state_nx = BURST;
        end else if (grant != '0) begin
          grant_bad = 1'b1;
        end
      end
      BURST: begin
        ch_ready[sel] = 1'b1;
        accept        = ch_valid[sel];
        if (accept) begin
          beat_nx = beat_inc;
          idle_nx = '0;
          if (ch_last[sel]) begin
            end_last = 1'b1;
            state_nx = ACK;
          end else if (beat_inc == BW'(MAX_BEATS)) begin
            end_last  = 1'b1;
            end_abort = 1'b1;
            state_nx  = ACK;
          end
        end else begin
          idle_nx = idle_inc;
          if (idle_inc == IW'(TIMEOUT)) begin
            end_abort = 1'b1;
            state_nx  = ACK;
          end
        end
      end
      ACK: begin
        ack      = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (grant != (G_ONE << sel)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      err_grant <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      beat_cnt  <= beat_nx;
      idle_cnt  <= idle_nx;
      out_valid <= accept;
      out_last  <= end_last;
      err_abort <= end_abort;
      if (accept) begin
        out_data <= ch_data[sel*DW +: DW];
        out_chan <= sel;
      end
      if (grant_bad) err_grant <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_grant_responder.sv
// Bench for rr_grant_responder: directed and random bursts checked against a
// burst-level model that predicts emitted beats, ack cycle and abort from the stimulus.
module tb_rr_grant_responder;
  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int MAX_BEATS = 8;
  localparam int TIMEOUT   = 15;
  localparam logic [N-1:0] G_ONE = N'(1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    grant, req, ch_valid, ch_last, ch_ready;
  logic [N*DW-1:0] ch_data;
  logic            ack, out_valid, out_last, err_grant, err_abort;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_chan;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bit         sv[128];
  bit         sl[128];
  logic [7:0] sd[128];

  rr_grant_responder #(.N(N), .DW(DW), .MAX_BEATS(MAX_BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .grant(grant), .req(req), .ch_valid(ch_valid),
    .ch_last(ch_last), .ch_data(ch_data), .ch_ready(ch_ready), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_last(out_last), .err_grant(err_grant), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_noise();
    ch_valid = N'($urandom);
    ch_last  = N'($urandom);
    req      = N'($urandom);
    for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic clear_stim();
    for (int j = 0; j < 128; j++) begin
      sv[j] = 1'b0;
      sl[j] = 1'b0;
      sd[j] = 8'($urandom);
    end
  endtask

  task automatic fill_random(input int mode);
    for (int j = 0; j < 128; j++) begin
      sd[j] = 8'($urandom);
      case (mode)
        0:       begin sv[j] = ($urandom_range(0, 3) != 0); sl[j] = ($urandom_range(0, 4) == 0); end
        1:       begin sv[j] = ($urandom_range(0, 3) != 0); sl[j] = 1'b0; end
        2:       begin sv[j] = (j < 3); sl[j] = 1'b0; end
        default: begin sv[j] = ($urandom_range(0, 9) == 0); sl[j] = $urandom_range(0, 1) != 0; end
      endcase
    end
  endtask

  // Window 0 starts with the grant presented; the first burst cycle is window 1+lead.
  task automatic run_burst(input int ch, input int lead, input bit jitter, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int beats = 0, idle = 0, end_j = -1, first_b, ack_w;
    bit abort = 1'b0, by_beat = 1'b0;
    int n_ack = 0, ack_at = -1, n_abt = 0, abt_at = -1;
    int n_rdy = 0, rdy_oor = 0, bad_rdy = 0, chan_bad = 0, n_last = 0, last_pos = -1;
    for (int j = 0; j < 128 && end_j < 0; j++) begin
      if (sv[j]) begin
        exp_q.push_back(sd[j]);
        beats++;
        idle = 0;
        if (sl[j]) begin
          end_j = j; by_beat = 1'b1;
        end else if (beats == MAX_BEATS) begin
          end_j = j; by_beat = 1'b1; abort = 1'b1;
        end
      end else begin
        idle++;
        if (idle == TIMEOUT) begin
          end_j = j; abort = 1'b1;
        end
      end
    end
    first_b = 1 + lead;
    ack_w   = end_j + first_b + 1;
    for (int w = 0; w <= ack_w; w++) begin
      int j;
      j = w - first_b;
      drive_noise();
      grant = G_ONE << ch;
      if (j >= 0 && j <= end_j) begin
        if (jitter) grant = G_ONE << ((ch + 1 + int'($urandom_range(0, N - 2))) % N);
        ch_valid[ch]          = sv[j];
        ch_last[ch]           = sl[j];
        ch_data[ch*DW +: DW]  = sd[j];
      end
      #1;
      for (int i = 0; i < N; i++) if (i != ch && ch_ready[i]) bad_rdy++;
      if (ch_ready[ch]) begin
        n_rdy++;
        if (j < 0 || j > end_j) rdy_oor++;
      end
      if (out_valid) begin
        obs_q.push_back(out_data);
        if (int'(out_chan) != ch) chan_bad++;
        if (out_last) begin
          n_last++;
          last_pos = obs_q.size() - 1;
        end
      end
      if (ack) begin n_ack++; ack_at = w; end
      if (err_abort) begin n_abt++; abt_at = w; end
      @(posedge clk); #1;
    end
    check({tag, "_ack_count"}, n_ack, 1);
    check({tag, "_ack_cycle"}, ack_at, ack_w);
    check({tag, "_abort_count"}, n_abt, abort ? 1 : 0);
    check({tag, "_abort_cycle"}, abt_at, abort ? ack_w : -1);
    check({tag, "_ready_cycles"}, n_rdy, end_j + 1);
    check({tag, "_ready_window"}, rdy_oor, 0);
    check({tag, "_ready_other"}, bad_rdy, 0);
    check({tag, "_beat_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < obs_q.size()) check({tag, "_beat_data"}, obs_q[k], exp_q[k]);
    check({tag, "_out_chan"}, chan_bad, 0);
    check({tag, "_last_count"}, n_last, by_beat ? 1 : 0);
    check({tag, "_last_pos"}, last_pos, by_beat ? exp_q.size() - 1 : -1);
  endtask

  task automatic quiet(input logic [N-1:0] g, input int n, input string tag);
    int n_ack = 0, n_rdy = 0, n_ov = 0, n_abt = 0;
    for (int w = 0; w < n; w++) begin
      drive_noise();
      grant = g;
      #1;
      if (ack) n_ack++;
      if (ch_ready != '0) n_rdy++;
      if (out_valid) n_ov++;
      if (err_abort) n_abt++;
      @(posedge clk); #1;
    end
    check({tag, "_ack"}, n_ack, 0);
    check({tag, "_ready"}, n_rdy, 0);
    check({tag, "_out_valid"}, n_ov, 0);
    check({tag, "_err_abort"}, n_abt, 0);
  endtask

  initial begin
    int ch, nch, lead, mode, n_ack;
    grant = '0; req = '0; ch_valid = '0; ch_last = '0; ch_data = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_ch_ready", ch_ready, 0);
    check("rst_ack", ack, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_grant", err_grant, 0);
    check("rst_err_abort", err_abort, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    quiet('0, 2, "idle");

    clear_stim();
    sv[0] = 1; sd[0] = 8'hA1;
    sv[1] = 1; sd[1] = 8'hA2;
    sv[2] = 1; sd[2] = 8'hA3; sl[2] = 1;
    run_burst(0, 0, 1'b0, "t1_single");
    check("t1_err_grant", err_grant, 0);
    quiet(4'b0001, 4, "t1_stale_grant");
    quiet('0, 2, "t1_release");

    clear_stim();
    sv[0] = 1; sv[1] = 1; sl[1] = 1;
    run_burst(0, 0, 1'b0, "t2_ch0");
    clear_stim();
    sv[0] = 1; sl[0] = 1; sd[0] = 8'h5C;
    run_burst(1, 1, 1'b0, "t2_rot_ch1");
    quiet('0, 2, "t2_release");

    clear_stim();
    for (int j = 0; j < 10; j++) sv[j] = 1;
    run_burst(2, 0, 1'b0, "t3_overrun");
    quiet('0, 2, "t3_release");

    clear_stim();
    for (int j = 0; j < 8; j++) sv[j] = 1;
    sl[7] = 1;
    run_burst(1, 0, 1'b0, "t3_last_at_limit");
    quiet('0, 2, "t3b_release");

    clear_stim();
    run_burst(3, 0, 1'b0, "t4_timeout");
    quiet('0, 2, "t4_release");

    fill_random(0);
    run_burst(0, 0, 1'b1, "grant_jitter");
    quiet('0, 2, "jitter_release");

    quiet(4'b0110, 3, "t5_bad_grant");
    check("t5_err_grant_set", err_grant, 1);
    clear_stim();
    sv[0] = 1; sv[1] = 1; sv[2] = 1; sl[2] = 1;
    run_burst(1, 0, 1'b0, "t5_after_bad");
    check("t5_err_grant_sticky", err_grant, 1);

    ch = 1;
    for (int k = 0; k < 24; k++) begin
      mode = int'($urandom_range(0, 3));
      fill_random(mode);
      if ($urandom_range(0, 1) != 0) begin
        quiet('0, int'($urandom_range(1, 3)), "rnd_gap");
        nch  = int'($urandom_range(0, N - 1));
        lead = 0;
      end else begin
        nch  = (ch + 1 + int'($urandom_range(0, N - 2))) % N;
        lead = 1;
      end
      run_burst(nch, lead, $urandom_range(0, 1) != 0, "rnd");
      ch = nch;
    end
    check("rnd_err_grant_sticky", err_grant, 1);
    quiet('0, 2, "rnd_release");

    drive_noise(); grant = 4'b0001; ch_valid[0] = 1'b0;
    @(posedge clk); #1;
    drive_noise(); ch_valid[0] = 1'b1; ch_last[0] = 1'b0; ch_data[7:0] = 8'hB1;
    @(posedge clk); #1;
    drive_noise(); ch_valid[0] = 1'b1; ch_last[0] = 1'b0; ch_data[7:0] = 8'hB2;
    @(posedge clk); #1;
    drive_noise(); ch_valid[0] = 1'b1; ch_last[0] = 1'b0; ch_data[7:0] = 8'hB3;
    #1;
    check("t6_pre_out_valid", out_valid, 1);
    check("t6_pre_out_data", out_data, 8'hB2);
    check("t6_pre_ready", ch_ready, 4'b0001);
    rst = 1'b1;
    #1;
    check("t6_rst_ch_ready", ch_ready, 0);
    check("t6_rst_ack", ack, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_out_chan", out_chan, 0);
    check("t6_rst_out_last", out_last, 0);
    check("t6_rst_err_grant", err_grant, 0);
    check("t6_rst_err_abort", err_abort, 0);
    n_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) n_ack++;
    end
    check("t6_no_ack_in_reset", n_ack, 0);
    rst = 1'b0;
    clear_stim();
    for (int j = 0; j < 9; j++) sv[j] = 1;
    run_burst(0, 0, 1'b0, "t6_fresh");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rr_grant_responder.md
Name: rr_grant_responder

Overview:
- Shared-resource end of the round-robin req/grant/ack handshake.
- Watches the arbiter's one-hot grant vector, latches the winning channel and drains one burst of data beats from it onto a single output stream.
- Pulses ack when the burst ends so the arbiter rotates priority.
- Sits between the arbiter and the downstream sink; the requesters' data buses fan in here.

Parameters:
N, 4, number of requesting channels (>=2)
DW, 8, data width per channel
MAX_BEATS, 8, maximum beats per grant; burst forcibly ended at this count
TIMEOUT, 15, idle cycles (no valid from granted channel) before burst is abandoned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
grant  in  N  one-hot grant from arbiter
req  in  N  request lines (monitored only)
ch_valid  in  N  per-channel beat valid
ch_last  in  N  per-channel last-beat marker
ch_data  in  N*DW  packed channel data, channel i at [i*DW +: DW]
ch_ready  out  N  per-channel ready; at most one bit set
ack  out  1  one-cycle completion pulse to arbiter
out_valid  out  1  registered output beat valid
out_data  out  DW  registered output data
out_chan  out  $clog2(N)  source channel of out_data
out_last  out  1  final beat of burst
err_grant  out  1  sticky: grant seen with more than one bit set
err_abort  out  1  one-cycle pulse: burst ended by MAX_BEATS or TIMEOUT

Behaviour:
- Reset (async, immediate): state IDLE; ch_ready, ack, out_valid, out_last, err_abort = 0; out_data, out_chan = 0; err_grant = 0; all counters = 0. Reset mid-burst drops the burst with no ack.
- FSM states: IDLE, BURST, ACK, WAIT.
- IDLE:
  - grant == 0: stay.
  - grant exactly one-hot: latch index to sel, clear beat_cnt and idle_cnt, go to BURST next cycle.
  - grant not one-hot and nonzero: set err_grant, stay in IDLE.
- BURST:
  - ch_ready[sel] = 1 combinationally; all other ch_ready bits 0.
  - Beat accepted when ch_valid[sel] & ch_ready[sel].
  - Accepted beat registers next cycle: out_valid=1, out_data=ch_data[sel], out_chan=sel. One-cycle latency; no backpressure from sink.
  - Each accepted beat increments beat_cnt and clears idle_cnt. A non-accepting cycle increments idle_cnt.
  - Exit to ACK when any of:
    - accepted beat carries ch_last[sel]: out_last=1 with that beat.
    - accepted beat brings beat_cnt to MAX_BEATS: out_last=1, err_abort pulses.
    - idle_cnt reaches TIMEOUT: no beat emitted, err_abort pulses.
  - If ch_last and the MAX_BEATS limit coincide, the burst is a normal end and err_abort stays 0.
  - req[sel] dropping mid-burst has no effect; only valid, last, limit and timeout end a burst.
  - A grant change during BURST is ignored; sel is held.
- ACK: ch_ready = 0; ack = 1 for exactly one cycle; go to WAIT.
- WAIT: stay until grant differs from the latched one-hot value or grant == 0, then go to IDLE. This prevents re-serving a stale grant the arbiter has not yet updated.
- Counter widths: beat_cnt is $clog2(MAX_BEATS+1) bits, idle_cnt is $clog2(TIMEOUT+1) bits. Neither wraps; both saturate at exit.
- Burst timing:
  - Minimum grant-to-ack: 3 cycles (latch, one last beat, ack).
  - Back-to-back grants: the next burst can start 2 cycles after ack (WAIT, IDLE).
- err_grant clears only on rst.

Test Plan:
1. Single burst: grant=0001; ch0 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd) -> out_data sequence A1,A2,A3 with out_chan=0, out_last on A3; ack one cycle after A3 accepted; err_abort=0.
2. Rotation: req=0011, grant 0001 then 0010 after ack; ch1 sends 1 beat 0x5C with last -> out_chan=1, data 0x5C; exactly two ack pulses total; ch_ready[0] never set while sel=1.
3. Overrun: grant=0100, ch2 streams 10 beats with no last -> exactly 8 beats output, out_last on the 8th, err_abort pulse; ch_ready[2] low from the 9th beat on.
4. Timeout: grant=1000, ch3 valid held low -> after 15 idle cycles err_abort pulses and ack pulses; out_valid never asserted.
5. Bad grant: grant=0110 in IDLE -> err_grant=1 and stays 1; no ch_ready, no ack. Grant then becomes 0010 -> normal burst proceeds.
6. Async reset mid-burst: assert rst after 2 of 4 beats on ch0 -> all outputs 0 immediately, no ack. After rst release with grant=0001, a fresh burst starts with beat_cnt=0.
